// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-ALU command sequencer: opcodes, ALU flag
// bit positions and the sequencer FSM encoding.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;

    localparam int FLG_SIGN  = 3;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_CARRY = 1;
    localparam int FLG_DONE  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_SEND1  = 3'd2,
        ST_SEND2  = 3'd3,
        ST_SENDOP = 3'd4,
        ST_WAIT   = 3'd5,
        ST_RESP   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/alu_seq_timer.sv
// Cycle counter for the WAIT state; saturates at LIMIT-1 and flags expiry there.
module alu_seq_timer #(
    parameter int LIMIT = 8,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != W'(LIMIT - 1))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Host-side driver for the 4-bit sequential nibble ALU: takes one command,
// resyncs the ALU, streams op1/op2/opcode, waits for done, returns a response.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op1,
    input  logic [3:0] cmd_op2,
    input  logic [3:0] cmd_opcode,
    output logic       alu_reset,
    output logic [3:0] alu_data,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       rsp_timeout,
    output seq_state_t dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // cmd_ready is high only in IDLE; rsp_* hold steady while rsp_valid && !rsp_ready.

    seq_state_t r_state, w_next;
    logic [3:0] r_op1, r_op2, r_opc;
    logic       r_cmd_ready, r_alu_reset, r_rsp_valid, r_rsp_timeout;
    logic [3:0] r_alu_data, r_rsp_result, r_rsp_flags;

    logic       w_latch, w_expired;
    logic       w_cmd_ready, w_alu_reset, w_rsp_valid, w_rsp_timeout;
    logic [3:0] w_alu_data, w_rsp_result, w_rsp_flags;

    alu_seq_timer #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (r_state == ST_SENDOP),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op1         <= '0;
            r_op2         <= '0;
            r_opc         <= '0;
            r_cmd_ready   <= 1'b1;
            r_alu_reset   <= 1'b1;
            r_alu_data    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cmd_ready   <= w_cmd_ready;
            r_alu_reset   <= w_alu_reset;
            r_alu_data    <= w_alu_data;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_result  <= w_rsp_result;
            r_rsp_flags   <= w_rsp_flags;
            r_rsp_timeout <= w_rsp_timeout;
            if (w_latch) begin
                r_op1 <= cmd_op1;
                r_op2 <= cmd_op2;
                r_opc <= cmd_opcode;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_latch       = 1'b0;
        w_rsp_result  = r_rsp_result;
        w_rsp_flags   = r_rsp_flags;
        w_rsp_timeout = r_rsp_timeout;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_latch = 1'b1;
                    w_next  = ST_SYNC;
                end
            end
            ST_SYNC:   w_next = ST_SEND1;
            ST_SEND1:  w_next = ST_SEND2;
            ST_SEND2:  w_next = ST_SENDOP;
            ST_SENDOP: w_next = ST_WAIT;
            ST_WAIT: begin
                // Done is checked first so it wins over a simultaneous expiry.
                if (alu_flags[FLG_DONE]) begin
                    w_rsp_result  = alu_result;
                    w_rsp_flags   = alu_flags;
                    w_rsp_timeout = 1'b0;
                    w_next        = ST_RESP;
                end else if (w_expired) begin
                    w_rsp_result  = '0;
                    w_rsp_flags   = '0;
                    w_rsp_timeout = 1'b1;
                    w_next        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with it.
        w_cmd_ready = (w_next == ST_IDLE);
        w_alu_reset = (w_next == ST_IDLE) || (w_next == ST_SYNC) || (w_next == ST_RESP);
        w_rsp_valid = (w_next == ST_RESP);
        case (w_next)
            ST_SEND1:         w_alu_data = r_op1;
            ST_SEND2:         w_alu_data = r_op2;
            ST_SENDOP,
            ST_WAIT:          w_alu_data = r_opc;
            default:          w_alu_data = '0;
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign alu_reset   = r_alu_reset;
    assign alu_data    = r_alu_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_timeout = r_rsp_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer, paired with a behavioural nibble ALU
// and a stub ALU that never raises done.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op1 = '0, cmd_op2 = '0, cmd_opcode = '0;
    logic       alu_reset;
    logic [3:0] alu_data;
    logic [3:0] alu_result, alu_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_result, rsp_flags;
    logic       rsp_timeout;
    seq_state_t dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic use_stub = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
        .alu_reset(alu_reset), .alu_data(alu_data),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout), .dbg_state(dbg_state)
    );

    // Behavioural nibble ALU: op1, op2, opcode on successive edges, then done.
    logic [1:0] m_cnt;
    logic [3:0] m_a, m_b, m_res, m_flg;

    function automatic logic [4:0] alu_fn(input logic [3:0] a, b, op);
        case (op)
            OP_SUB:  alu_fn = {a < b, a - b};
            OP_AND:  alu_fn = {1'b0, a & b};
            OP_OR:   alu_fn = {1'b0, a | b};
            OP_NOT:  alu_fn = {1'b0, ~a};
            OP_NAND: alu_fn = {1'b0, ~(a & b)};
            OP_NOR:  alu_fn = {1'b0, ~(a | b)};
            default: alu_fn = {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [4:0] v;
        if (alu_reset) begin
            m_cnt <= 2'd0; m_res <= '0; m_flg <= '0;
        end else begin
            case (m_cnt)
                2'd0: begin m_a <= alu_data; m_cnt <= 2'd1; end
                2'd1: begin m_b <= alu_data; m_cnt <= 2'd2; end
                2'd2: begin
                    v = alu_fn(m_a, m_b, alu_data);
                    m_res <= v[3:0];
                    m_flg <= {v[3], v[3:0] == 4'd0, v[4], 1'b1};
                    m_cnt <= 2'd3;
                end
                default: ;
            endcase
        end
    end

    assign alu_result = use_stub ? 4'hA : m_res;
    assign alu_flags  = use_stub ? 4'hE : m_flg;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge while IDLE; returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] a, b, op);
        cmd_op1 = a; cmd_op2 = b; cmd_opcode = op; cmd_valid = 1'b1;
        chk("cmd_ready_before", {7'd0, cmd_ready}, 8'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("state_sync", {5'd0, dbg_state}, {5'd0, ST_SYNC});
        chk("alu_reset_sync", {7'd0, alu_reset}, 8'd1);
        chk("cmd_ready_busy", {7'd0, cmd_ready}, 8'd0);
    endtask

    task automatic check_send(input logic [3:0] a, b, op);
        @(negedge clk);
        chk("send1_data", {4'd0, alu_data}, {4'd0, a});
        chk("send1_alu_reset", {7'd0, alu_reset}, 8'd0);
        @(negedge clk);
        chk("send2_data", {4'd0, alu_data}, {4'd0, b});
        @(negedge clk);
        chk("sendop_data", {4'd0, alu_data}, {4'd0, op});
    endtask

    // Counts negedges until rsp_valid, bounded; checks the count.
    task automatic wait_rsp(input int exp_n);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 8'(n), 8'(exp_n));
    endtask

    task automatic check_rsp(input logic [3:0] res, flg, input logic to);
        chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("rsp_result", {4'd0, rsp_result}, {4'd0, res});
        chk("rsp_flags", {4'd0, rsp_flags}, {4'd0, flg});
        chk("rsp_timeout", {7'd0, rsp_timeout}, {7'd0, to});
    endtask

    task automatic take_rsp();
        @(negedge clk);
        chk("rsp_valid_after_take", {7'd0, rsp_valid}, 8'd0);
        chk("cmd_ready_after_take", {7'd0, cmd_ready}, 8'd1);
    endtask

    task automatic run_cmd(input logic [3:0] a, b, op, res, flg);
        issue(a, b, op);
        check_send(a, b, op);
        wait_rsp(2);
        check_rsp(res, flg, 1'b0);
        take_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] held_res, held_flg;

        // 1 reset
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_alu_reset", {7'd0, alu_reset}, 8'd1);
        chk("rst_alu_data", {4'd0, alu_data}, 8'd0);
        chk("rst_rsp_timeout", {7'd0, rsp_timeout}, 8'd0);
        chk("rst_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_release", {7'd0, cmd_ready}, 8'd1);

        // 2 ADD 9+8 = 17 -> 1, carry
        run_cmd(4'd9, 4'd8, OP_ADD, 4'h1, 4'b0011);

        // 3 SUB 3-3 -> zero; then SUB 2-5 -> sign, borrow, zero cleared
        run_cmd(4'd3, 4'd3, OP_SUB, 4'h0, 4'b0101);
        run_cmd(4'd2, 4'd5, OP_SUB, 4'hD, 4'b1011);

        // 4 backpressure: AND C&A = 8 held for 5 cycles, second command (OR 5|3) waits
        rsp_ready = 1'b0;
        issue(4'hC, 4'hA, OP_AND);
        check_send(4'hC, 4'hA, OP_AND);
        wait_rsp(2);
        check_rsp(4'h8, 4'b1001, 1'b0);
        held_res = rsp_result;
        held_flg = rsp_flags;
        cmd_op1 = 4'd5; cmd_op2 = 4'd3; cmd_opcode = OP_OR; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {7'd0, rsp_valid}, 8'd1);
            chk("bp_result_stable", {4'd0, rsp_result}, {4'd0, held_res});
            chk("bp_flags_stable", {4'd0, rsp_flags}, {4'd0, held_flg});
            chk("bp_cmd_ready", {7'd0, cmd_ready}, 8'd0);
            chk("bp_state", {5'd0, dbg_state}, {5'd0, ST_RESP});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_back_idle", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        chk("bp_rsp_dropped", {7'd0, rsp_valid}, 8'd0);
        chk("bp_cmd_ready_idle", {7'd0, cmd_ready}, 8'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_accepted", {5'd0, dbg_state}, {5'd0, ST_SYNC});
        check_send(4'd5, 4'd3, OP_OR);
        wait_rsp(2);
        check_rsp(4'h7, 4'b0001, 1'b0);
        take_rsp();

        // 5 stub ALU never signals done: timeout after 8 WAIT cycles
        use_stub = 1'b1;
        issue(4'd1, 4'd2, OP_ADD);
        check_send(4'd1, 4'd2, OP_ADD);
        wait_rsp(9);
        check_rsp(4'h0, 4'h0, 1'b1);
        take_rsp();
        use_stub = 1'b0;

        // 6 reset during SEND2 drops the command; a new one completes
        issue(4'd4, 4'd4, OP_ADD);
        @(negedge clk);
        @(negedge clk);
        chk("mid_state_send2", {5'd0, dbg_state}, {5'd0, ST_SEND2});
        reset = 1'b1;
        #1;
        chk("mid_rst_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        chk("mid_rst_alu_reset", {7'd0, alu_reset}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end
        chk("mid_rsp_timeout_clear", {7'd0, rsp_timeout}, 8'd0);
        run_cmd(4'd7, 4'd1, OP_ADD, 4'h8, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
